// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: instruction fields,
// state numbering and datapath select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_MUL   = 6'b011000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_MUL_WAIT  = 4'd3,
        S_WB_R      = 4'd4,
        S_EXEC_ADDI = 4'd5,
        S_WB_I      = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_RD    = 4'd8,
        S_WB_LW     = 4'd9,
        S_MEM_WR    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_ERROR     = 4'd15
    } state_t;

    typedef enum logic [1:0] {PC_ALU = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3} pc_src_t;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} wb_sel_t;
    typedef enum logic [1:0] {RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2} reg_dst_t;
    typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2} alu_op_t;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_BRANCH = 2'd3;

endpackage

// File: rtl/wait_timer.sv
// Up-counter that bounds how long the controller may sit in a wait state;
// expired flags the last cycle allowed before a timeout.
module wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [4:0] LAST = 5'(WAIT_LIMIT - 1);

    logic [4:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick)
            count <= count + 5'd1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: sequences fetch, decode, execute,
// memory and writeback, with bounded waits on memory and the multiplier.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | compute branch target, dispatch on opcode/funct
// EXEC_R     | R-type ALU op, or launch multiplier
// MUL_WAIT   | wait for mul_done
// WB_R       | write rd
// EXEC_ADDI  | rs + imm
// WB_I       | write rt with ALU result
// MEM_ADDR   | rs + imm as memory address
// MEM_RD     | load access
// WB_LW      | write rt with memory data
// MEM_WR     | store access
// BRANCH     | compare, take branch on zero
// JUMP       | j / jal
// ERROR      | illegal instruction or timeout, held until reset
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_write,
    output logic       mul_start,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       err,
    output logic [3:0] state_o
);

    state_t state, state_next;
    logic   tick, clear, expired;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    // Any state change restarts the count, so each wait state starts at zero.
    assign clear = (state_next != state);

    wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .tick    (tick),
        .expired (expired)
    );

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        reg_write  = 1'b0;
        mul_start  = 1'b0;
        pc_src     = PC_ALU;
        reg_dst    = RD_RT;
        wb_sel     = WB_ALU;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        err        = 1'b0;
        tick       = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    tick      = !mem_ready;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_en      = 1'b1;
                        pc_src     = PC_ALU;
                        state_next = S_DECODE;
                    end else if (expired) begin
                        state_next = S_ERROR;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BRANCH;
                    alu_op    = ALU_ADD;
                    case (opcode)
                        OP_RTYPE: begin
                            case (funct)
                                FN_ADD, FN_SUB, FN_MUL: state_next = S_EXEC_R;
                                FN_JR: begin
                                    pc_en      = 1'b1;
                                    pc_src     = PC_RS;
                                    state_next = S_FETCH;
                                end
                                default: state_next = S_ERROR;
                            endcase
                        end
                        OP_ADDI:      state_next = S_EXEC_ADDI;
                        OP_LW, OP_SW: state_next = S_MEM_ADDR;
                        OP_BEQ:       state_next = S_BRANCH;
                        OP_J, OP_JAL: state_next = S_JUMP;
                        default:      state_next = S_ERROR;
                    endcase
                end
                S_EXEC_R: begin
                    if (funct == FN_MUL) begin
                        mul_start  = 1'b1;
                        state_next = S_MUL_WAIT;
                    end else begin
                        alu_op     = ALU_FUNCT;
                        state_next = S_WB_R;
                    end
                end
                S_MUL_WAIT: begin
                    tick = !mul_done;
                    if (mul_done)
                        state_next = S_WB_R;
                    else if (expired)
                        state_next = S_ERROR;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RD;
                    wb_sel     = WB_ALU;
                    state_next = S_FETCH;
                end
                S_EXEC_ADDI: begin
                    alu_src_b  = SRCB_IMM;
                    alu_op     = ALU_ADD;
                    state_next = S_WB_I;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RT;
                    wb_sel     = WB_ALU;
                    state_next = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_b  = SRCB_IMM;
                    alu_op     = ALU_ADD;
                    state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD, S_MEM_WR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (state == S_MEM_WR);
                    tick    = !mem_ready;
                    if (mem_ready)
                        state_next = (state == S_MEM_RD) ? S_WB_LW : S_FETCH;
                    else if (expired)
                        state_next = S_ERROR;
                end
                S_WB_LW: begin
                    reg_write  = 1'b1;
                    reg_dst    = RD_RT;
                    wb_sel     = WB_MEM;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_op     = ALU_SUB;
                    pc_en      = zero;
                    pc_src     = PC_BRANCH;
                    state_next = S_FETCH;
                end
                S_JUMP: begin
                    pc_en      = 1'b1;
                    pc_src     = PC_JUMP;
                    state_next = S_FETCH;
                    if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = RD_RA;
                        wb_sel    = WB_PC;
                    end
                end
                // ERROR and the unused encodings both park in ERROR.
                default: begin
                    err        = 1'b1;
                    state_next = S_ERROR;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// an expected per-cycle trace from the behavioural rules, then replayed.
module tb_multicycle_control;

    localparam int L = 16;

    logic       clk, rst_n, zero, mem_ready, mul_done;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, mul_start, err;
    logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b, alu_op;
    logic [3:0] state_o;

    multicycle_control #(.WAIT_LIMIT(L)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mul_done(mul_done),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .reg_write(reg_write), .mul_start(mul_start),
        .pc_src(pc_src), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .err(err), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, mul_start, err;
        logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b, alu_op;
        logic       chk_op, chk_srcb;
        logic       rdy, done, zero;
    } cyc_t;

    cyc_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic [3:0] st);
        cyc_t c;
        c = '{default: '0};
        c.st   = st;
        c.rdy  = 1'($urandom);
        c.done = 1'($urandom);
        c.zero = 1'($urandom);
        return c;
    endfunction

    // Awaited signal low for d cycles then high; d >= L means it never comes in time.
    task automatic wait_phase(input cyc_t tw, input cyc_t tr, input int d, input bit on_mul, output bit ok);
        cyc_t c;
        int   n;
        n  = (d >= L) ? L : d + 1;
        ok = (d < L);
        for (int k = 0; k < n; k++) begin
            c = (ok && k == n - 1) ? tr : tw;
            c.rdy  = 1'($urandom);
            c.done = 1'($urandom);
            c.zero = 1'($urandom);
            if (on_mul) c.done = (ok && k == n - 1);
            else        c.rdy  = (ok && k == n - 1);
            q.push_back(c);
        end
    endtask

    task automatic push_err();
        cyc_t c;
        for (int k = 0; k < 3; k++) begin
            c = mk(4'd15);
            c.err = 1'b1;
            q.push_back(c);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
               op == 6'h04 || op == 6'h02 || op == 6'h03;
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h18 || fn == 6'h08;
    endfunction

    task automatic build(input logic [31:0] ins, input int df, input int dw, input bit zb, output bit err_end);
        logic [5:0] op, fn;
        cyc_t       t, r;
        bit         ok;
        op = ins[31:26];
        fn = ins[5:0];
        err_end = 1'b0;

        t = mk(4'd0); t.mem_req = 1'b1; t.iord = 1'b0;
        r = t; r.ir_write = 1'b1; r.pc_en = 1'b1; r.pc_src = 2'd0;
        wait_phase(t, r, df, 1'b0, ok);
        if (!ok) begin push_err(); err_end = 1'b1; return; end

        t = mk(4'd1); t.chk_op = 1'b1; t.alu_op = 2'd0; t.chk_srcb = 1'b1; t.alu_src_b = 2'd3;
        if (op == 6'h00 && fn == 6'h08) begin
            t.pc_en = 1'b1; t.pc_src = 2'd3;
            q.push_back(t);
            return;
        end
        q.push_back(t);
        if (!legal_op(op) || (op == 6'h00 && !legal_fn(fn))) begin
            push_err(); err_end = 1'b1; return;
        end

        if (op == 6'h00) begin
            t = mk(4'd2);
            if (fn == 6'h18) begin
                t.mul_start = 1'b1;
                q.push_back(t);
                t = mk(4'd3);
                wait_phase(t, t, dw, 1'b1, ok);
                if (!ok) begin push_err(); err_end = 1'b1; return; end
            end else begin
                t.chk_op = 1'b1; t.alu_op = 2'd2;
                q.push_back(t);
            end
            t = mk(4'd4); t.reg_write = 1'b1; t.reg_dst = 2'd1; t.wb_sel = 2'd0;
            q.push_back(t);
        end else if (op == 6'h08) begin
            t = mk(4'd5); t.chk_op = 1'b1; t.alu_op = 2'd0; t.chk_srcb = 1'b1; t.alu_src_b = 2'd2;
            q.push_back(t);
            t = mk(4'd6); t.reg_write = 1'b1; t.reg_dst = 2'd0; t.wb_sel = 2'd0;
            q.push_back(t);
        end else if (op == 6'h23 || op == 6'h2B) begin
            t = mk(4'd7); t.chk_op = 1'b1; t.alu_op = 2'd0; t.chk_srcb = 1'b1; t.alu_src_b = 2'd2;
            q.push_back(t);
            t = mk((op == 6'h23) ? 4'd8 : 4'd10);
            t.mem_req = 1'b1; t.iord = 1'b1; t.mem_we = (op == 6'h2B);
            wait_phase(t, t, dw, 1'b0, ok);
            if (!ok) begin push_err(); err_end = 1'b1; return; end
            if (op == 6'h23) begin
                t = mk(4'd9); t.reg_write = 1'b1; t.reg_dst = 2'd0; t.wb_sel = 2'd1;
                q.push_back(t);
            end
        end else if (op == 6'h04) begin
            t = mk(4'd11); t.zero = zb; t.chk_op = 1'b1; t.alu_op = 2'd1;
            t.pc_en = zb; t.pc_src = 2'd1;
            q.push_back(t);
        end else begin
            t = mk(4'd12); t.pc_en = 1'b1; t.pc_src = 2'd2;
            if (op == 6'h03) begin t.reg_write = 1'b1; t.reg_dst = 2'd2; t.wb_sel = 2'd2; end
            q.push_back(t);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        opcode    = 6'($urandom);
        funct     = 6'($urandom);
        mem_ready = 1'($urandom);
        mul_done  = 1'($urandom);
        zero      = 1'($urandom);
        #1;
        chk("rst_strobes", 4'({mem_req, mem_we, ir_write, pc_en}), 4'd0);
        chk("rst_wr_mul",  4'({reg_write, mul_start}), 4'd0);
        chk("rst_err",     4'(err), 4'd0);
    endtask

    task automatic run_txn(input logic [31:0] ins, input int df, input int dw, input bit zb, input int trunc);
        bit   e;
        int   n;
        cyc_t c;
        q.delete();
        build(ins, df, dw, zb, e);
        n = (trunc > 0 && trunc < q.size()) ? trunc : q.size();
        for (int i = 0; i < n; i++) begin
            c = q[i];
            @(negedge clk);
            rst_n     = 1'b1;
            opcode    = ins[31:26];
            funct     = ins[5:0];
            mem_ready = c.rdy;
            mul_done  = c.done;
            zero      = c.zero;
            #1;
            chk("state", state_o, c.st);
            chk("mem_req", 4'(mem_req), 4'(c.mem_req));
            if (c.mem_req) chk("iord", 4'(iord), 4'(c.iord));
            chk("mem_we", 4'(mem_we), 4'(c.mem_we));
            chk("ir_write", 4'(ir_write), 4'(c.ir_write));
            chk("pc_en", 4'(pc_en), 4'(c.pc_en));
            if (c.pc_en) chk("pc_src", 4'(pc_src), 4'(c.pc_src));
            chk("reg_write", 4'(reg_write), 4'(c.reg_write));
            if (c.reg_write) begin
                chk("reg_dst", 4'(reg_dst), 4'(c.reg_dst));
                chk("wb_sel", 4'(wb_sel), 4'(c.wb_sel));
            end
            chk("mul_start", 4'(mul_start), 4'(c.mul_start));
            chk("err", 4'(err), 4'(c.err));
            if (c.chk_op)   chk("alu_op", 4'(alu_op), 4'(c.alu_op));
            if (c.chk_srcb) chk("alu_src_b", 4'(alu_src_b), 4'(c.alu_src_b));
        end
        if (e || n < q.size()) do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h18;
            3: fn = 6'h08;
            default: fn = 6'($urandom);
        endcase
        case (k)
            4: op = 6'h08;
            5: op = 6'h23;
            6: op = 6'h2B;
            7: op = 6'h04;
            8: op = 6'h02;
            9: op = 6'h03;
            10: begin
                op = 6'($urandom);
                while (legal_op(op)) op = 6'($urandom);
            end
            11: begin
                op = 6'h00;
                while (legal_fn(fn)) fn = 6'($urandom);
            end
            default: op = 6'h00;
        endcase
        return {op, 20'($urandom), fn};
    endfunction

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return L;
        if (r == 1) return L - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
        do_reset();
        do_reset();

        run_txn(32'h200400A1, 0, 0, 1'b0, 0);      // addi
        run_txn(32'hAE050004, 0, 2, 1'b0, 0);      // sw, ready on 3rd MEM_WR cycle
        run_txn(32'h11090008, 0, 0, 1'b1, 0);      // beq taken
        run_txn(32'h11090008, 1, 0, 1'b0, 0);      // beq not taken
        run_txn(32'h00864018, 0, 4, 1'b0, 0);      // mul, 5-cycle MUL_WAIT
        run_txn(32'h0C00000D, 0, 0, 1'b0, 0);      // jal
        run_txn(32'hFC000000, 0, 0, 1'b0, 0);      // illegal opcode 0x3F
        run_txn(32'h200400A1, L, 0, 1'b0, 0);      // fetch timeout
        run_txn(32'h200400A1, L - 1, 0, 1'b0, 0);  // ready on the last allowed cycle
        run_txn(32'h8C000000, 0, 6, 1'b0, 5);      // reset on 3rd MEM_RD cycle
        run_txn(32'h00864018, 0, L, 1'b0, 0);      // multiplier timeout
        run_txn(32'h03E00008, 0, 0, 1'b0, 0);      // jr

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ins;
            int trunc;
            ins   = rand_instr();
            trunc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0;
            run_txn(ins, rand_delay(), rand_delay(), 1'($urandom), trunc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 16, maximum cycles any wait state may last before ERROR (range 2..32).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 opcode  input  6  instruction register bits [31:26].
REQ-005 funct  input  6  instruction register bits [5:0].
REQ-006 zero  input  1  ALU zero flag, used in the BRANCH state.
REQ-007 mem_ready  input  1  unified memory completes the current access this cycle.
REQ-008 mul_done  input  1  multiplier result valid this cycle.
REQ-009 mem_req / mem_we / iord  output  1 each  memory access strobe / write / address select (0 = PC, 1 = ALU result).
REQ-010 ir_write / pc_en / reg_write / mul_start  output  1 each  register-file and unit strobes.
REQ-011 pc_src  output  2  PC source: 0 = ALU (PC+4), 1 = branch target, 2 = jump target, 3 = rs.
REQ-012 reg_dst / wb_sel / alu_src_b / alu_op  output  2 each  datapath selects.
REQ-013 err  output  1  sticky fault flag.
REQ-014 state_o  output  4  current state, for debug.

Function
REQ-015 The block SHALL support these instructions and no others:
- R-type (opcode 000000) with funct 100000 add, 100010 sub, 011000 mul, 001000 jr.
- addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-016 State encoding SHALL be: FETCH=0, DECODE=1, EXEC_R=2, MUL_WAIT=3, WB_R=4, EXEC_ADDI=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, WB_LW=9, MEM_WR=10, BRANCH=11, JUMP=12, ERROR=15.
REQ-017 FETCH SHALL behave as follows:
- Assert mem_req with iord=0 every cycle.
- On mem_ready: assert ir_write, and pc_en with pc_src=0, in that same cycle; then go to DECODE.
REQ-018 DECODE SHALL compute the branch target (alu_src_b=3, alu_op=0 add), then transition:
- R add/sub/mul go to EXEC_R.
- jr asserts pc_en with pc_src=3 and goes to FETCH.
- addi goes to EXEC_ADDI; lw/sw go to MEM_ADDR; beq goes to BRANCH; j/jal go to JUMP.
- Any other opcode/funct goes to ERROR.
REQ-019 EXEC_R SHALL drive alu_op=2 for add/sub and go to WB_R; for mul it SHALL pulse mul_start for one cycle and go to MUL_WAIT.
REQ-020 MUL_WAIT SHALL hold until mul_done, then go to WB_R.
REQ-021 WB_R and WB_I SHALL each assert reg_write for one cycle, then go to FETCH:
- WB_R: reg_dst=1 (rd), wb_sel=0.
- WB_I: reg_dst=0 (rt), wb_sel=0.
REQ-022 EXEC_ADDI and MEM_ADDR SHALL drive alu_src_b=2 (sign-extended immediate) with alu_op=0.
REQ-023 MEM_ADDR SHALL go to MEM_RD for lw and to MEM_WR for sw.
REQ-024 MEM_RD and MEM_WR SHALL assert mem_req with iord=1 until mem_ready; MEM_WR additionally asserts mem_we.
- MEM_RD then goes to WB_LW.
- MEM_WR then goes to FETCH.
REQ-025 WB_LW SHALL assert reg_write with reg_dst=0 and wb_sel=1, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_op=1 (subtract), assert pc_en with pc_src=1 only when zero=1, and go to FETCH.
REQ-027 JUMP SHALL assert pc_en with pc_src=2 and go to FETCH; for jal it SHALL also assert reg_write with reg_dst=2 ($ra) and wb_sel=2 (PC, already incremented).
REQ-028 Wait counting SHALL work as follows:
- A 5-bit wait counter clears on entry to FETCH, MUL_WAIT, MEM_RD or MEM_WR.
- It increments each cycle the awaited ready/done signal is low.
- If that signal is low while count == WAIT_LIMIT-1, the next state SHALL be ERROR.
- A ready/done arriving in that same cycle SHALL win.
REQ-029 ERROR SHALL assert err, hold all other strobes at 0, and remain until reset.
REQ-030 Outputs SHALL be combinational from state, opcode, funct, zero, mem_ready and mul_done; any strobe not named for a state SHALL be 0.

Reset
REQ-031 While rst_n=0, all strobes and err SHALL be forced to 0.
REQ-032 On the clock edge with rst_n=0, the state SHALL load FETCH, the wait counter SHALL load 0, and err SHALL load 0.
REQ-033 A reset asserted in any state, including mid-access, SHALL abandon the operation without issuing further strobes.
REQ-034 After rst_n rises, mem_req SHALL assert in the first cycle.

Structure
REQ-035 Package mips_ctrl_pkg SHALL hold the opcode/funct constants, the state encoding, and the pc_src, wb_sel, reg_dst and alu_op encodings.
REQ-036 The wait counter SHALL be a sub-module named wait_timer, with ports clk, rst_n, clear, tick and expired.

Verification
REQ-037 addi (0x200400A1) with mem_ready high in FETCH -> states 0,1,5,6, then FETCH; reg_write=1 only in cycle 4 with reg_dst=0 and wb_sel=0.
REQ-038 sw (0xAE050004) with mem_ready first high on the 3rd MEM_WR cycle -> mem_we=1 for exactly 3 cycles with iord=1, then FETCH.
REQ-039 beq (0x11090008): zero=1 -> pc_en=1 with pc_src=1 in BRANCH; zero=0 -> pc_en=0 in BRANCH.
REQ-040 mul (0x00864018) with mul_done after 5 cycles -> mul_start is a single pulse, MUL_WAIT lasts 5 cycles, then WB_R with reg_dst=1.
REQ-041 jal (0x0C00000D) -> JUMP asserts pc_en with pc_src=2 and reg_write with reg_dst=2 and wb_sel=2; illegal opcode 0x3F -> ERROR, err=1 held.
REQ-042 mem_ready held low in FETCH -> ERROR after exactly WAIT_LIMIT (16) cycles; a separate case with rst_n=0 during MEM_RD -> FETCH next cycle with all strobes 0.
